// File: rtl/trs_video_char_fetch.sv
// trs_video_char_fetch: per-scan-line character fetch, glyph and
// block-graphics cell builder, and pixel serializer for Model 1 video.
module trs_video_char_fetch #(
   parameter int COLS = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_pix_en,
   input  logic        i_line_start,
   input  logic [3:0]  i_text_row,
   input  logic [3:0]  i_scan_row,
   input  logic        i_wide,
   output logic [9:0]  o_vram_addr,
   input  logic [7:0]  i_vram_data,
   output logic [10:0] o_font_addr,
   input  logic [5:0]  i_font_data,
   output logic        o_pixel,
   output logic        o_pixel_valid,
   output logic        o_line_done,
   output logic        o_underrun
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_VADDR,
      S_FADDR,
      S_LATCH
   } state_t;

   localparam logic [6:0] LP_FULL = 7'(COLS);
   localparam logic [6:0] LP_HALF = 7'(COLS / 2);

   state_t     r_state;
   state_t     w_state_nxt;

   logic       r_armed;
   logic       r_wide;
   logic [3:0] r_text_row;
   logic [3:0] r_scan_row;
   logic       r_end_pend;
   logic       r_line_done;

   logic [6:0] r_fetch_cnt;
   logic [9:0] r_vram_addr;
   // code bit 7 (graphics flag) and bits 5:0 (block pattern)
   logic [6:0] r_code_q;
   logic [5:0] r_next_bits;
   logic       r_next_valid;

   logic [5:0] r_shift;
   logic [3:0] r_left;
   logic       r_phase;
   logic [6:0] r_cell_cnt;
   logic       r_pixel;
   logic       r_pixel_valid;
   logic       r_underrun;

   logic [6:0]  w_len;
   logic [5:0]  w_col;
   logic        w_go;
   logic [10:0] w_font_addr;
   logic        w_left_bit;
   logic        w_right_bit;
   logic [5:0]  w_cell;
   logic        w_pe;
   logic        w_emit;
   logic        w_last_pix;
   logic        w_need;
   logic        w_load;
   logic        w_stall;

   assign w_len = r_wide ? LP_HALF : LP_FULL;
   assign w_col = r_wide ? {r_fetch_cnt[4:0], 1'b0}
                         : r_fetch_cnt[5:0];
   assign w_go  = r_armed && !r_next_valid
                  && (r_fetch_cnt < w_len);

   // A pixel slot is usable only when no new line is being armed
   // and the line-end pulse is not pending.
   assign w_pe       = i_pix_en && !i_line_start && !r_end_pend;
   assign w_emit     = w_pe && (r_left != 4'd0);
   assign w_last_pix = (r_left == 4'd1) && (r_cell_cnt == w_len);
   assign w_need     = w_pe && (r_left == 4'd0) && r_armed
                       && (r_cell_cnt < w_len);
   assign w_load     = w_need && r_next_valid;
   assign w_stall    = w_need && !r_next_valid;

   // Fetch FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Fetch FSM next state; font address is live only in FADDR.
   always_comb begin
      w_state_nxt = r_state;
      w_font_addr = '0;
      unique case (r_state)
         S_IDLE: begin
            if (w_go) begin
               w_state_nxt = S_VADDR;
            end
         end
         S_VADDR: begin
            w_state_nxt = S_FADDR;
         end
         S_FADDR: begin
            w_state_nxt = S_LATCH;
            w_font_addr = {1'b0, i_vram_data[6:0],
                           r_scan_row[2:0]};
         end
         S_LATCH: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (i_line_start) begin
         w_state_nxt = S_IDLE;
      end
   end

   // Block-graphics pair select and cell build from code and ROM row.
   always_comb begin
      w_left_bit  = 1'b0;
      w_right_bit = 1'b0;
      unique case (1'b1)
         (r_scan_row[3:2] == 2'd0): begin
            w_left_bit  = r_code_q[0];
            w_right_bit = r_code_q[1];
         end
         (r_scan_row[3:2] == 2'd1): begin
            w_left_bit  = r_code_q[2];
            w_right_bit = r_code_q[3];
         end
         (r_scan_row[3:2] == 2'd2): begin
            w_left_bit  = r_code_q[4];
            w_right_bit = r_code_q[5];
         end
         default: begin
            w_left_bit  = 1'b0;
            w_right_bit = 1'b0;
         end
      endcase
      if (r_code_q[6]) begin
         w_cell = {{3{w_left_bit}}, {3{w_right_bit}}};
      end else if (r_scan_row[3]) begin
         w_cell = 6'd0;
      end else begin
         w_cell = i_font_data;
      end
   end

   // Line arming, latched line parameters and the line-end pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_armed     <= 1'b0;
         r_wide      <= 1'b0;
         r_text_row  <= '0;
         r_scan_row  <= '0;
         r_end_pend  <= 1'b0;
         r_line_done <= 1'b0;
      end else if (i_line_start) begin
         r_armed     <= 1'b1;
         r_wide      <= i_wide;
         r_text_row  <= i_text_row;
         r_scan_row  <= i_scan_row;
         r_end_pend  <= 1'b0;
         r_line_done <= 1'b0;
      end else if (r_end_pend) begin
         r_armed     <= 1'b0;
         r_end_pend  <= 1'b0;
         r_line_done <= 1'b1;
      end else begin
         r_line_done <= 1'b0;
         if (w_emit && w_last_pix) begin
            r_end_pend <= 1'b1;
         end
      end
   end

   // Fetch datapath: VRAM address, code capture, next-cell buffer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fetch_cnt  <= '0;
         r_vram_addr  <= '0;
         r_code_q     <= '0;
         r_next_bits  <= '0;
         r_next_valid <= 1'b0;
      end else if (i_line_start) begin
         r_fetch_cnt  <= '0;
         r_next_valid <= 1'b0;
      end else begin
         if (w_load) begin
            r_next_valid <= 1'b0;
         end
         unique case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_vram_addr <= {r_text_row, w_col};
               end
            end
            S_FADDR: begin
               r_code_q <= {i_vram_data[7], i_vram_data[5:0]};
            end
            S_LATCH: begin
               r_next_bits  <= w_cell;
               r_next_valid <= 1'b1;
               r_fetch_cnt  <= r_fetch_cnt + 7'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Pixel shifter: emit MSB per pix_en, doubled in wide mode.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift       <= '0;
         r_left        <= '0;
         r_phase       <= 1'b0;
         r_cell_cnt    <= '0;
         r_pixel       <= 1'b0;
         r_pixel_valid <= 1'b0;
         r_underrun    <= 1'b0;
      end else if (i_line_start || r_end_pend) begin
         r_shift       <= '0;
         r_left        <= '0;
         r_phase       <= 1'b0;
         r_pixel       <= 1'b0;
         r_pixel_valid <= 1'b0;
         if (i_line_start) begin
            r_cell_cnt <= '0;
         end
      end else if (w_emit) begin
         r_pixel       <= r_shift[5];
         r_pixel_valid <= 1'b1;
         r_left        <= r_left - 4'd1;
         if (!r_wide || r_phase) begin
            r_shift <= {r_shift[4:0], 1'b0};
            r_phase <= 1'b0;
         end else begin
            r_phase <= 1'b1;
         end
      end else if (w_load) begin
         r_pixel       <= r_next_bits[5];
         r_pixel_valid <= 1'b1;
         r_cell_cnt    <= r_cell_cnt + 7'd1;
         if (r_wide) begin
            r_shift <= r_next_bits;
            r_phase <= 1'b1;
            r_left  <= 4'd11;
         end else begin
            r_shift <= {r_next_bits[4:0], 1'b0};
            r_phase <= 1'b0;
            r_left  <= 4'd5;
         end
      end else if (w_stall) begin
         r_pixel       <= 1'b0;
         r_pixel_valid <= 1'b0;
         r_underrun    <= 1'b1;
      end else if (i_pix_en) begin
         r_pixel       <= 1'b0;
         r_pixel_valid <= 1'b0;
      end
   end

   assign o_vram_addr   = r_vram_addr;
   assign o_font_addr   = w_font_addr;
   assign o_pixel       = r_pixel;
   assign o_pixel_valid = r_pixel_valid;
   assign o_line_done   = r_line_done;
   assign o_underrun    = r_underrun;

endmodule
